// File: rtl/alu_seq.sv
// alu_seq: multi-cycle ALU with a start/busy/done handshake.
// Single-cycle logic/shift/arith ops plus iterative MULU, DIVU and REMU.
//
// Ports:
//   clock   rising-edge clock
//   resetn  asynchronous active-low reset
//   start   request, sampled only while idle
//   aluc    4-bit operation code, captured with start
//   a, b    WIDTH-bit operands, captured with start
//   s       registered result, held until the next result
//   z       registered, 1 when s == 0
//   ovf     registered signed overflow (ADD/SUB only)
//   busy    high whenever the unit is not idle
//   done    one-cycle pulse, s/z/ovf valid from this cycle on
module alu_seq #(
   parameter int WIDTH = 32,
   parameter int SHW   = $clog2(WIDTH)
) (
   input  logic             clock,
   input  logic             resetn,
   input  logic             start,
   input  logic [3:0]       aluc,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] s,
   output logic             z,
   output logic             ovf,
   output logic             busy,
   output logic             done
);

   localparam logic [3:0] OP_ADD  = 4'b0000;
   localparam logic [3:0] OP_SUB  = 4'b0100;
   localparam logic [3:0] OP_AND  = 4'b0001;
   localparam logic [3:0] OP_OR   = 4'b0101;
   localparam logic [3:0] OP_XOR  = 4'b0010;
   localparam logic [3:0] OP_LUI  = 4'b0110;
   localparam logic [3:0] OP_SLL  = 4'b0011;
   localparam logic [3:0] OP_SRL  = 4'b0111;
   localparam logic [3:0] OP_SRA  = 4'b1111;
   localparam logic [3:0] OP_PAR  = 4'b1011;
   localparam logic [3:0] OP_MULU = 4'b1000;
   localparam logic [3:0] OP_DIVU = 4'b1010;
   localparam logic [3:0] OP_REMU = 4'b1100;

   localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);
   localparam logic [SHW-1:0]   LAST = SHW'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      DONE
   } state_t;

   state_t           state;
   logic [SHW-1:0]   cnt;
   logic [3:0]       opc;
   // acc: product accumulator (MULU) or partial remainder (DIVU/REMU)
   // opx: shifted multiplicand (MULU) or dividend/quotient (DIVU/REMU)
   // opy: shifted multiplier (MULU) or divisor (DIVU/REMU)
   logic [WIDTH-1:0] acc;
   logic [WIDTH-1:0] opx;
   logic [WIDTH-1:0] opy;

   // single-cycle datapath, fed straight from the inputs at acceptance
   logic [WIDTH-1:0] sc_s;
   logic             sc_ovf;
   logic [WIDTH-1:0] b_neg;
   logic [WIDTH-1:0] sum;
   logic [WIDTH-1:0] dif;
   logic [SHW-1:0]   sh;
   logic             is_iter;

   always_comb begin
      b_neg  = ~b + ONE;
      sum    = a + b;
      dif    = a + b_neg;
      sh     = a[SHW-1:0];
      sc_s   = '0;
      sc_ovf = 1'b0;
      unique case (1'b1)
         (aluc == OP_ADD): begin
            sc_s   = sum;
            sc_ovf = (a[WIDTH-1] == b[WIDTH-1]) &&
                     (sum[WIDTH-1] != a[WIDTH-1]);
         end
         (aluc == OP_SUB): begin
            sc_s   = dif;
            sc_ovf = (a[WIDTH-1] == b_neg[WIDTH-1]) &&
                     (dif[WIDTH-1] != a[WIDTH-1]);
         end
         (aluc == OP_AND): sc_s = a & b;
         (aluc == OP_OR):  sc_s = a | b;
         (aluc == OP_XOR): sc_s = a ^ b;
         (aluc == OP_LUI): sc_s = b << (WIDTH / 2);
         (aluc == OP_SLL): sc_s = b << sh;
         (aluc == OP_SRL): sc_s = b >> sh;
         (aluc == OP_SRA): sc_s = $signed(b) >>> sh;
         (aluc == OP_PAR): sc_s = {{(WIDTH-1){1'b0}}, (^a) ^ (^b)};
         default:          sc_s = '0;
      endcase
   end

   assign is_iter = (aluc == OP_MULU) ||
                    (aluc == OP_DIVU) ||
                    (aluc == OP_REMU);

   // one shift-add multiply step
   logic [WIDTH-1:0] acc_m;

   always_comb begin
      acc_m = opy[0] ? (acc + opx) : acc;
   end

   // one restoring-division step; the divisor is never zero-checked,
   // so b == 0 naturally yields all-ones quotient and remainder a
   logic [WIDTH:0]   rem_sh;
   logic             rem_ge;
   logic [WIDTH-1:0] rem_n;
   logic [WIDTH-1:0] quo_n;

   always_comb begin
      rem_sh = {acc, opx[WIDTH-1]};
      rem_ge = rem_sh >= {1'b0, opy};
      // difference is below the divisor, so WIDTH bits suffice
      rem_n  = rem_ge ? (rem_sh[WIDTH-1:0] - opy) : rem_sh[WIDTH-1:0];
      quo_n  = {opx[WIDTH-2:0], rem_ge};
   end

   logic [WIDTH-1:0] it_s;

   always_comb begin
      it_s = '0;
      unique case (1'b1)
         (opc == OP_MULU): it_s = acc_m;
         (opc == OP_DIVU): it_s = quo_n;
         default:          it_s = rem_n;
      endcase
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state <= IDLE;
         cnt   <= '0;
         opc   <= '0;
         acc   <= '0;
         opx   <= '0;
         opy   <= '0;
         s     <= '0;
         z     <= 1'b0;
         ovf   <= 1'b0;
         busy  <= 1'b0;
         done  <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (start) begin
                  opc  <= aluc;
                  opx  <= a;
                  opy  <= b;
                  acc  <= '0;
                  busy <= 1'b1;
                  if (is_iter) begin
                     state <= CALC;
                     cnt   <= LAST;
                  end else begin
                     state <= DONE;
                     done  <= 1'b1;
                     s     <= sc_s;
                     z     <= (sc_s == '0);
                     ovf   <= sc_ovf;
                  end
               end
            end
            CALC: begin
               if (opc == OP_MULU) begin
                  acc <= acc_m;
                  opx <= opx << 1;
                  opy <= opy >> 1;
               end else begin
                  acc <= rem_n;
                  opx <= quo_n;
               end
               if (cnt == '0) begin
                  state <= DONE;
                  done  <= 1'b1;
                  s     <= it_s;
                  z     <= (it_s == '0);
                  ovf   <= 1'b0;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            DONE: begin
               state <= IDLE;
               done  <= 1'b0;
               busy  <= 1'b0;
            end
            default: begin
               state <= IDLE;
               done  <= 1'b0;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: self-checking bench for alu_seq.
// Directed vector table, random ops against a reference model, corner sequences.
module tb_alu_seq;

   logic        clock = 1'b0;
   logic        resetn;
   logic        start;
   logic [3:0]  aluc;
   logic [31:0] a;
   logic [31:0] b;
   logic [31:0] s;
   logic        z;
   logic        ovf;
   logic        busy;
   logic        done;

   int total = 0;
   int bad   = 0;

   alu_seq #(.WIDTH(32)) dut (
      .clock  (clock),
      .resetn (resetn),
      .start  (start),
      .aluc   (aluc),
      .a      (a),
      .b      (b),
      .s      (s),
      .z      (z),
      .ovf    (ovf),
      .busy   (busy),
      .done   (done)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic [3:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] s;
      logic        z;
      logic        ovf;
      int          lat;
   } vec_t;

   vec_t tbl[16];

   task automatic check(input string name, input logic [63:0] act,
                        input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   // reference: plain arithmetic straight from the operation rules
   function automatic void model(input logic [3:0] op,
                                 input logic [31:0] x, input logic [31:0] y,
                                 output logic [31:0] r, output logic v,
                                 output int lat);
      longint      t;
      logic [31:0] yn;
      v   = 1'b0;
      lat = 1;
      yn  = -y;
      case (op)
         4'b0000: begin
            r = x + y;
            t = longint'($signed(x)) + longint'($signed(y));
            v = (t != longint'($signed(r)));
         end
         4'b0100: begin
            r = x - y;
            t = longint'($signed(x)) + longint'($signed(yn));
            v = (t != longint'($signed(r)));
         end
         4'b0001: r = x & y;
         4'b0101: r = x | y;
         4'b0010: r = x ^ y;
         4'b0110: r = y * 32'd65536;
         4'b0011: r = y * (32'd1 << x[4:0]);
         4'b0111: r = y / (32'd1 << x[4:0]);
         4'b1111: r = 32'($signed(y) >>> x[4:0]);
         4'b1011: r = {31'd0, (^x) ^ (^y)};
         4'b1000: begin r = x * y; lat = 33; end
         4'b1010: begin r = (y == 0) ? 32'hFFFF_FFFF : x / y; lat = 33; end
         4'b1100: begin r = (y == 0) ? x : x % y; lat = 33; end
         default: r = 32'd0;
      endcase
   endfunction

   task automatic run_op(input logic [3:0] op, input logic [31:0] ia,
                         input logic [31:0] ib, output int lat,
                         output int gaps);
      @(negedge clock);
      aluc  = op;
      a     = ia;
      b     = ib;
      start = 1'b1;
      @(posedge clock);
      #1;
      start = 1'b0;
      a     = $urandom;
      b     = $urandom;
      aluc  = 4'($urandom);
      lat   = 0;
      gaps  = 0;
      do begin
         @(negedge clock);
         lat++;
         if (!busy) gaps++;
      end while (!done && lat < 200);
   endtask

   task automatic apply(input string name, input logic [3:0] op,
                        input logic [31:0] ia, input logic [31:0] ib,
                        input logic [31:0] es, input logic ez,
                        input logic eo, input int elat, input bit tail);
      int          lat;
      int          gaps;
      logic [31:0] held;
      run_op(op, ia, ib, lat, gaps);
      check({name, " lat"}, 64'(lat), 64'(elat));
      check({name, " s"}, {32'd0, s}, {32'd0, es});
      check({name, " z"}, {63'd0, z}, {63'd0, ez});
      check({name, " ovf"}, {63'd0, ovf}, {63'd0, eo});
      check({name, " busy"}, 64'(gaps), 64'd0);
      held = s;
      @(negedge clock);
      if (tail) begin
         check({name, " busy after"}, {63'd0, busy}, 64'd0);
         check({name, " done after"}, {63'd0, done}, 64'd0);
         check({name, " s held"}, {32'd0, s}, {32'd0, held});
      end
   endtask

   initial begin
      int          dones;
      logic [31:0] cap;
      logic [3:0]  rop;
      logic [31:0] ra;
      logic [31:0] rb;
      logic [31:0] rs;
      logic        rv;
      int          rl;

      tbl[0]  = '{4'b0000, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 0, 1, 1};
      tbl[1]  = '{4'b0100, 32'd5, 32'd5, 32'h0, 1, 0, 1};
      tbl[2]  = '{4'b1111, 32'd4, 32'hF000_0000, 32'hFF00_0000, 0, 0, 1};
      tbl[3]  = '{4'b0011, 32'h21, 32'h1, 32'h2, 0, 0, 1};
      tbl[4]  = '{4'b1000, 32'h0001_0003, 32'h0001_0005, 32'h0008_000F, 0, 0, 33};
      tbl[5]  = '{4'b1010, 32'd100, 32'd7, 32'd14, 0, 0, 33};
      tbl[6]  = '{4'b1100, 32'd100, 32'd7, 32'd2, 0, 0, 33};
      tbl[7]  = '{4'b1010, 32'd9, 32'd0, 32'hFFFF_FFFF, 0, 0, 33};
      tbl[8]  = '{4'b1100, 32'd9, 32'd0, 32'd9, 0, 0, 33};
      tbl[9]  = '{4'b0001, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 0, 0, 1};
      tbl[10] = '{4'b0101, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hFFF0_FFF0, 0, 0, 1};
      tbl[11] = '{4'b0010, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0, 0, 0, 1};
      tbl[12] = '{4'b0110, 32'h0, 32'h1234, 32'h1234_0000, 0, 0, 1};
      tbl[13] = '{4'b0111, 32'd4, 32'hF000_0000, 32'h0F00_0000, 0, 0, 1};
      tbl[14] = '{4'b1001, 32'd5, 32'd6, 32'h0, 1, 0, 1};
      tbl[15] = '{4'b0100, 32'h8000_0000, 32'h1, 32'h7FFF_FFFF, 0, 1, 1};

      resetn = 1'b0;
      start  = 1'b0;
      aluc   = 4'd0;
      a      = 32'd0;
      b      = 32'd0;
      repeat (3) @(negedge clock);
      resetn = 1'b1;
      @(negedge clock);
      check("reset s", {32'd0, s}, 64'd0);
      check("reset z", {63'd0, z}, 64'd0);
      check("reset ovf", {63'd0, ovf}, 64'd0);
      check("reset busy", {63'd0, busy}, 64'd0);
      check("reset done", {63'd0, done}, 64'd0);

      for (int i = 0; i < 16; i++)
         apply($sformatf("vec%0d", i), tbl[i].op, tbl[i].a, tbl[i].b,
               tbl[i].s, tbl[i].z, tbl[i].ovf, tbl[i].lat, 1'b1);

      for (int i = 0; i < 80; i++) begin
         rop = 4'($urandom_range(0, 15));
         ra  = $urandom;
         rb  = $urandom;
         if (i % 4 == 1) rb = 32'($urandom_range(0, 20));
         if (i % 7 == 3) ra = 32'h8000_0000;
         model(rop, ra, rb, rs, rv, rl);
         apply($sformatf("rnd%0d op%0h", i, rop), rop, ra, rb,
               rs, (rs == 32'd0), rv, rl, (i % 5 == 0));
      end

      // new request and operand changes during a MULU are ignored
      @(negedge clock);
      aluc  = 4'b1000;
      a     = 32'd3;
      b     = 32'h0001_0001;
      start = 1'b1;
      @(posedge clock);
      #1;
      start = 1'b0;
      dones = 0;
      cap   = 32'd0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clock);
         if (i == 5) begin
            start = 1'b1;
            aluc  = 4'b0000;
         end
         if (i >= 5 && i < 8) begin
            a = $urandom;
            b = $urandom;
         end
         if (i == 8) start = 1'b0;
         if (done) begin
            dones++;
            cap = s;
            check("mid mulu lat", 64'(i + 1), 64'd33);
         end
      end
      check("mid mulu dones", 64'(dones), 64'd1);
      check("mid mulu s", {32'd0, cap}, 64'h0003_0003);

      // reset during DIVU iteration 10
      @(negedge clock);
      aluc  = 4'b1010;
      a     = 32'd1000;
      b     = 32'd3;
      start = 1'b1;
      @(posedge clock);
      #1;
      start = 1'b0;
      repeat (10) @(negedge clock);
      check("div busy", {63'd0, busy}, 64'd1);
      check("div no done", {63'd0, done}, 64'd0);
      resetn = 1'b0;
      #1;
      check("abort s", {32'd0, s}, 64'd0);
      check("abort z", {63'd0, z}, 64'd0);
      check("abort busy", {63'd0, busy}, 64'd0);
      check("abort done", {63'd0, done}, 64'd0);
      dones = 0;
      repeat (2) @(negedge clock);
      resetn = 1'b1;
      for (int i = 0; i < 40; i++) begin
         @(negedge clock);
         if (done) dones++;
      end
      check("abort dones", 64'(dones), 64'd0);
      apply("par after rst", 4'b1011, 32'd1, 32'd0, 32'd1, 0, 0, 1, 1'b1);

      // start held high: accepted every other cycle
      @(negedge clock);
      aluc  = 4'b0000;
      a     = 32'd1;
      b     = 32'd2;
      start = 1'b1;
      dones = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clock);
         if (done) dones++;
         check($sformatf("held done%0d", i), {63'd0, done},
               {63'd0, (i % 2 == 0)});
      end
      start = 1'b0;
      check("held dones", 64'(dones), 64'd5);
      check("held s", {32'd0, s}, 64'd3);
      repeat (3) @(negedge clock);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1);
   end

endmodule
